// File: rtl/frame_pkg.sv
// Shared definitions for the frame read/write datapath: FSM state
// encoding, default frame geometry, and a counter-width helper.
package frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int FRAME_WIDTH  = 480;
    localparam int FRAME_HEIGHT = 272;
    localparam int FRAME_DEPTH  = FRAME_WIDTH * FRAME_HEIGHT;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_writer_rgb888_start_sync.sv
// start_sync: brings a level request from another clock domain in through
// a two-flop synchronizer and emits a registered one-cycle pulse on its
// rising edge. Shared by the frame writer and the frame reader.
module start_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    // Synchronizer chain, edge history and registered rising-edge pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/frame_writer_rgb888.sv
// frame_writer_rgb888: writes a valid-tagged raster pixel stream into a
// frame BRAM through one write port. Address is a running counter (no
// multiplier); col/row counters detect the last pixel of the frame.
// Optional feature: define FRAME_WR_PINGPONG_EN for two alternating frame
// banks at base 0 and base DEPTH.
module frame_writer_rgb888
    import frame_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 17,
    parameter int WIDTH  = FRAME_WIDTH,
    parameter int HEIGHT = FRAME_HEIGHT,
    parameter int DEPTH  = FRAME_DEPTH
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iPixel,
    output logic              oCs,
    output logic              oWe,
    output logic [ADDR_W-1:0] oAddr,
    output logic [DATA_W-1:0] oData,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr,
    output logic              oBank
);

    localparam int COL_W = cnt_width(WIDTH);
    localparam int ROW_W = cnt_width(HEIGHT);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0]  COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};
    localparam logic [ROW_W-1:0]  ROW_ONE  = {{(ROW_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Geometry sanity checks evaluated at elaboration.
    if (DEPTH != WIDTH * HEIGHT) begin : g_depth_check
        $error("frame_writer_rgb888: DEPTH must equal WIDTH*HEIGHT");
    end
`ifdef FRAME_WR_PINGPONG_EN
    if ((64'(2) * 64'(DEPTH)) > (64'd1 << ADDR_W)) begin : g_addr_check
        $error("frame_writer_rgb888: ADDR_W too small for two frame banks");
    end
`else
    if (64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_addr_check
        $error("frame_writer_rgb888: ADDR_W too small for one frame");
    end
`endif

    logic start_pulse_s;
    logic [ADDR_W-1:0] base_s;

    state_e            state_q,   state_d;
    logic [COL_W-1:0]  col_q,     col_d;
    logic [ROW_W-1:0]  row_q,     row_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              err_q,     err_d;
    logic              bank_q,    bank_d;
    logic              wr_q,      wr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;

    start_sync u_start_sync (
        .clk_i   (iClk),
        .rst_ni  (iRst),
        .async_i (iStart),
        .pulse_o (start_pulse_s)
    );

`ifdef FRAME_WR_PINGPONG_EN
    assign base_s = bank_q ? ADDR_W'(DEPTH) : {ADDR_W{1'b0}};
`else
    assign base_s = {ADDR_W{1'b0}};
`endif

    // Next-state, counter, flag and write-port logic.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        err_d     = err_q;
        bank_d    = bank_q;
        wr_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                // The start edge clears the error flag; a beat arriving in
                // the same cycle is dropped without re-setting it.
                if (start_pulse_s) begin
                    state_d = ST_WRITE;
                    col_d   = {COL_W{1'b0}};
                    row_d   = {ROW_W{1'b0}};
                    addr_d  = base_s;
                    err_d   = 1'b0;
                end else if (iValid) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            ST_WRITE: begin
                if (iValid) begin
                    wr_d      = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = iPixel;
                    addr_d    = addr_q + ADDR_ONE;
                    if (col_q == COL_LAST) begin
                        col_d = {COL_W{1'b0}};
                        if (row_q == ROW_LAST) begin
                            row_d   = {ROW_W{1'b0}};
                            state_d = ST_DONE;
                        end else begin
                            row_d = row_q + ROW_ONE;
                        end
                    end else begin
                        col_d = col_q + COL_ONE;
                    end
                end else begin
                    wr_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef FRAME_WR_PINGPONG_EN
                bank_d  = ~bank_q;
`endif
                if (iValid) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, counters, flags and the registered BRAM write port.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q   <= ST_IDLE;
            col_q     <= {COL_W{1'b0}};
            row_q     <= {ROW_W{1'b0}};
            addr_q    <= {ADDR_W{1'b0}};
            err_q     <= 1'b0;
            bank_q    <= 1'b0;
            wr_q      <= 1'b0;
            wr_addr_q <= {ADDR_W{1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            bank_q    <= bank_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign oCs   = wr_q;
    assign oWe   = wr_q;
    assign oAddr = wr_addr_q;
    assign oData = wr_data_q;
    assign oBusy = busy_q;
    assign oDone = done_q;
    assign oErr  = err_q;
    assign oBank = bank_q;

endmodule

// File: tb/tb_frame_writer_rgb888.sv
// Scoreboard bench for frame_writer_rgb888 with a 4x3 frame. Stimulus
// pushes expected writes into a queue; a negedge monitor pops and compares.
// Honors FRAME_WR_PINGPONG_EN for bank/base expectations.
module tb_frame_writer_rgb888;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int D  = 12;
    localparam int AW = 17;
    localparam int DW = 24;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          valid;
    logic [DW-1:0] pixel;
    logic          cs, we, busy, done, err, bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;

    wr_t exp_q[$];
    int  n_cmp     = 0;
    int  n_bad     = 0;
    int  done_cnt  = 0;
    bit  prev_done = 1'b0;
    int  exp_bank  = 0;

    always #5 clk = ~clk;

    frame_writer_rgb888 #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .WIDTH  (W),
        .HEIGHT (H),
        .DEPTH  (D)
    ) dut (
        .iClk   (clk),
        .iRst   (rst_n),
        .iStart (start),
        .iValid (valid),
        .iPixel (pixel),
        .oCs    (cs),
        .oWe    (we),
        .oAddr  (addr),
        .oData  (data),
        .oBusy  (busy),
        .oDone  (done),
        .oErr   (err),
        .oBank  (bank)
    );

    function automatic void check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard on every write and checks done/busy.
    always @(negedge clk) begin
        wr_t e;
        check("cs_eq_we", longint'(cs), longint'(we));
        if (we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0d data %0d, expected no write", addr, data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", longint'(addr), longint'(e.addr));
                check("wr_data", longint'(data), longint'(e.data));
            end
        end
        if (done) begin
            done_cnt++;
            check("busy_during_done", longint'(busy), 1);
        end
        if (prev_done) begin
            check("busy_after_done", longint'(busy), 0);
        end
        prev_done = done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cs"},   longint'(cs),   0);
        check({tag, "_we"},   longint'(we),   0);
        check({tag, "_addr"}, longint'(addr), 0);
        check({tag, "_data"}, longint'(data), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_err"},  longint'(err),  0);
        check({tag, "_bank"}, longint'(bank), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        step();
        step();
        rst_n    = 1'b1;
        exp_bank = 0;
    endtask

    // Lower start, raise it, expect busy exactly 4 steps later
    // (sync, sync, edge register, FSM).
    task automatic start_frame();
        int n;
        start = 1'b0;
        repeat (3) step();
        start = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!busy && n < 20);
        check("start_latency", n, 4);
    endtask

    task automatic run_frame(input bit gappy, input bit toggle_start);
        int base;
        int d0;
        int n;
        base = (exp_bank != 0) ? D : 0;
        d0   = done_cnt;
        for (int i = 0; i < D; i++) begin
            if (toggle_start && i == 5) start = 1'b0;
            if (toggle_start && i == 8) start = 1'b1;
            exp_q.push_back({AW'(base + i), DW'(i)});
            valid = 1'b1;
            pixel = DW'(i);
            step();
            if (i == 0) check("first_write_latency", longint'(we), 1);
            valid = 1'b0;
            if (gappy) begin
                step();
                check("no_write_in_gap", longint'(we), 0);
                step();
            end
        end
        n = 0;
        while (busy && n < 10) begin
            step();
            n++;
        end
        check("frame_end_idle", longint'(busy), 0);
        check("done_pulses", done_cnt - d0, 1);
        check("queue_drained", exp_q.size(), 0);
`ifdef FRAME_WR_PINGPONG_EN
        exp_bank = exp_bank ^ 1;
`endif
        check("bank", longint'(bank), exp_bank);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        pixel = '0;

        // Reset state.
        do_reset();
        check_zero("reset");

        // Contiguous frame.
        start_frame();
        run_frame(1'b0, 1'b0);

        // Frame with 1,0,0 valid pattern.
        start_frame();
        run_frame(1'b1, 1'b0);

        // Stray beats in IDLE set the sticky error; start clears it.
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            pixel = DW'(100 + i);
            step();
        end
        valid = 1'b0;
        step();
        check("err_after_idle_beats", longint'(err), 1);
        start_frame();
        check("err_cleared_by_start", longint'(err), 0);
        run_frame(1'b0, 1'b0);

        // Reset mid-frame after beat 6, then a fresh frame from addr 0.
        start_frame();
        base = (exp_bank != 0) ? D : 0;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({AW'(base + i), DW'(i)});
            valid = 1'b1;
            pixel = DW'(i);
            step();
        end
        valid = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        step();
        check_zero("midreset");
        rst_n    = 1'b1;
        exp_bank = 0;
        check("midreset_queue", exp_q.size(), 0);
        start_frame();
        run_frame(1'b0, 1'b0);

        // Second start edge mid-frame is ignored.
        start_frame();
        run_frame(1'b0, 1'b1);

        // Two back-to-back frames from a clean reset (bank 0 -> 1 -> 0).
        do_reset();
        check("bank_initial", longint'(bank), 0);
        start_frame();
        run_frame(1'b0, 1'b0);
        start_frame();
        run_frame(1'b0, 1'b0);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_writer_rgb888.md
# frame_writer_rgb888

Raster-order frame writer for the RGB888 filter datapath: takes the valid-tagged pixel stream produced downstream of the 3x3 window/MAC stage and writes it back into a frame BRAM through a single write port. It generates the BRAM chip-select, write-enable, and linear address from column and row counters. It signals frame completion with a one-cycle pulse and flags stray input beats.

## Interface
Parameters:
- DATA_W, 24, pixel width (RGB888)
- ADDR_W, 17, BRAM address width
- WIDTH, 480, pixels per row
- HEIGHT, 272, rows per frame
- DEPTH, 130560, pixels per frame (WIDTH*HEIGHT)

Ports:
- iClk  in  1  clock
- iRst  in  1  reset; synchronous, active-low
- iStart  in  1  frame arm request; asynchronous origin, level
- iValid  in  1  input pixel beat valid
- iPixel  in  DATA_W  input pixel
- oCs  out  1  BRAM chip select
- oWe  out  1  BRAM write enable
- oAddr  out  ADDR_W  BRAM write address
- oData  out  DATA_W  BRAM write data
- oBusy  out  1  frame in progress
- oDone  out  1  one-cycle frame-complete pulse
- oErr  out  1  sticky: beat received while not in WRITE
- oBank  out  1  active frame bank

## Operation
- iStart passes through a 2-flop synchronizer and a rising-edge detector. Only the edge arms a frame.
- FSM states:
  - IDLE: wait for the start edge. On the edge, clear counters and oErr, then go to WRITE.
  - WRITE: every iValid beat is written. Go to DONE when the beat at row HEIGHT-1, col WIDTH-1 is accepted.
  - DONE: one cycle, then IDLE.
- Column counter wraps at WIDTH-1 and increments the row counter.
- Address is a running counter, incremented per accepted beat, with no multiplier. Address = base + row*WIDTH + col. Last address is DEPTH-1 (130559 at defaults).
- iValid low in WRITE: no write, counters hold. Gaps of any length are legal.
- iValid high in IDLE or DONE: beat dropped, no write, oErr set. oErr clears only on the next start edge or on reset.
- A start edge during WRITE or DONE is ignored.
- Reset at any point clears every register, including mid-frame. The partial frame is abandoned.
- oBusy = (state != IDLE).

## Timing
- Reset values: oCs=0, oWe=0, oAddr=0, oData=0, oBusy=0, oDone=0, oErr=0, oBank=0.
- Start latency: iStart first sampled high at edge N → FSM in WRITE from edge N+3.
- Write latency: one register stage. A beat accepted at edge K drives oCs=oWe=1 with its oAddr/oData during cycle K+1.
- oCs == oWe. Both are high only for a write cycle.
- oDone is high for the cycle after the last write is issued, i.e. while the FSM is in DONE.
- Sustained throughput is one pixel per clock. There is no backpressure, so the source must not exceed one beat per cycle.

## Configuration
- FRAME_WR_PINGPONG_EN defined:
  - Two frame regions with base 0 and base DEPTH. ADDR_W must cover 2*DEPTH; this is checked by an elaboration-time assertion.
  - oBank toggles on the DONE state.
  - The base for the next frame is DEPTH when oBank=1.
  - Reset returns oBank to 0.
- FRAME_WR_PINGPONG_EN undefined: base is always 0 and oBank is tied 0.

## Structure
- Shared package frame_pkg holds:
  - FSM state encoding (IDLE=2'd0, WRITE=2'd1, DONE=2'd2)
  - default WIDTH/HEIGHT/DEPTH constants, shared with the window generator.
- Sub-module start_sync: 2-flop synchronizer plus rising-edge pulse. It is reusable by the read side.
- Top-level logic: FSM, col/row/address counters, output register stage, error and bank flags.

## Test plan
Benches run with WIDTH=4, HEIGHT=3, DEPTH=12 unless stated otherwise.
- Reset then iStart held high, then 12 contiguous beats with pixel=i → 12 writes to addr 0..11 with data 0..11, one per cycle, starting 1 cycle after the first beat; oDone pulses once; oBusy falls the cycle after oDone.
- Same frame with iValid toggling 1,0,0,1… → addresses still 0..11 in order, no write during gaps, col/row wrap correct (beat 4 → addr 4 = row1 col0).
- 3 beats in IDLE, then start, then a full frame → no writes before start, oErr=1 until the start edge then 0, frame written normally.
- iRst low for 1 cycle after beat 6 → all outputs 0 next edge, FSM IDLE; a fresh start writes from addr 0.
- Second start edge mid-frame → ignored, address sequence uninterrupted.
- With FRAME_WR_PINGPONG_EN: two consecutive frames → first frame writes addr 0..11, second writes addr 12..23; oBank goes 0→1→0.
